cavlc_scan_ctrl: RTL and testbench

//  Sequencer for the CAVLC front end of the H.264 encoder.
//  - Accepts one quantised 4x4 block per handshake and loads it into the zigzag reorder register bank by pulsing its write enable.
//  - Walks the 16 reordered coefficients from highest scan index down, computing TotalCoeff, TrailingOnes and TotalZeros.
//  - Streams the non-zero coefficients, with their scan index, to the CAVLC code generator.

---
 rtl/cavlc_pkg.sv | 26 ++
 rtl/cavlc_coef_sel.sv | 15 +
 rtl/cavlc_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cavlc_scan_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// Shared constants, types and helpers for the CAVLC scan controller.
package cavlc_pkg;

    localparam int COEF_W = 15;
    localparam int NCOEF  = 16;
    localparam int IDX_W  = $clog2(NCOEF);

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SCAN = 3'd2,
        ST_STAT = 3'd3,
        ST_EMIT = 3'd4
    } scan_state_e;

    // +1 and -1 only; the most negative code is not a unit.
    function automatic logic is_unit(input coef_t c);
        logic unit_s;
        unit_s = (c == coef_t'({{(COEF_W-1){1'b0}}, 1'b1})) ||
                 (c == coef_t'({COEF_W{1'b1}}));
        return unit_s;
    endfunction

endpackage

// File: rtl/cavlc_coef_sel.sv
// Picks one coefficient out of the zigzag bank outputs by scan index.
module cavlc_coef_sel
    import cavlc_pkg::*;
(
    input  logic [NCOEF*COEF_W-1:0] zz_dout,
    input  logic [IDX_W-1:0]        idx,
    output logic [COEF_W-1:0]       coef
);

    // NCOEF:1 mux shared by the scan and emit passes
    always_comb begin
        coef = zz_dout[idx*COEF_W +: COEF_W];
    end

endmodule

// File: rtl/cavlc_scan_ctrl.sv
// CAVLC front-end sequencer: loads a 4x4 block into the zigzag bank, derives
// TotalCoeff/TrailingOnes/TotalZeros, then streams non-zero coefficients high to low.
module cavlc_scan_ctrl
    import cavlc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    blk_valid,
    input  logic                    blk_ac,
    output logic                    blk_ready,
    output logic                    zz_wen,
    input  logic [NCOEF*COEF_W-1:0] zz_dout,
    output logic                    stat_valid,
    input  logic                    stat_ready,
    output logic [4:0]              total_coeff,
    output logic [1:0]              trail_ones,
    output logic [3:0]              total_zeros,
    output logic                    coef_valid,
    input  logic                    coef_ready,
    output logic [COEF_W-1:0]       coef_data,
    output logic [3:0]              coef_idx,
    output logic                    coef_last
);

    scan_state_e        state_r, state_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [IDX_W-1:0]   start_r, start_s;
    logic [IDX_W-1:0]   first_nz_r, first_nz_s;
    logic [4:0]         tc_r, tc_s;
    logic [1:0]         t1_r, t1_s;
    logic [3:0]         tz_r, tz_s;
    logic               t1_open_r, t1_open_s;
    logic [4:0]         emit_cnt_r, emit_cnt_s;
    logic [COEF_W-1:0]  sel_s;
    coef_t              c_s;
    logic               nz_s;
    logic               last_s;

    cavlc_coef_sel u_coef_sel (
        .zz_dout (zz_dout),
        .idx     (idx_r),
        .coef    (sel_s)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 4'd0;
            start_r    <= 4'd0;
            first_nz_r <= 4'd0;
            tc_r       <= 5'd0;
            t1_r       <= 2'd0;
            tz_r       <= 4'd0;
            t1_open_r  <= 1'b0;
            emit_cnt_r <= 5'd0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            start_r    <= start_s;
            first_nz_r <= first_nz_s;
            tc_r       <= tc_s;
            t1_r       <= t1_s;
            tz_r       <= tz_s;
            t1_open_r  <= t1_open_s;
            emit_cnt_r <= emit_cnt_s;
        end
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        start_s    = start_r;
        first_nz_s = first_nz_r;
        tc_s       = tc_r;
        t1_s       = t1_r;
        tz_s       = tz_r;
        t1_open_s  = t1_open_r;
        emit_cnt_s = emit_cnt_r;
        blk_ready  = 1'b0;
        zz_wen     = 1'b0;
        stat_valid = 1'b0;
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        c_s        = coef_t'(sel_s);
        nz_s       = (c_s != coef_t'({COEF_W{1'b0}}));
        last_s     = ((emit_cnt_r + 5'd1) == tc_r);

        case (state_r)
            ST_IDLE: begin
                blk_ready = 1'b1;
                zz_wen    = blk_valid;
                if (blk_valid) begin
                    start_s = blk_ac ? 4'd1 : 4'd0;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                idx_s      = 4'd15;
                first_nz_s = 4'd0;
                tc_s       = 5'd0;
                t1_s       = 2'd0;
                tz_s       = 4'd0;
                t1_open_s  = 1'b1;
                emit_cnt_s = 5'd0;
                state_s    = ST_SCAN;
            end
            ST_SCAN: begin
                if (nz_s) begin
                    tc_s = tc_r + 5'd1;
                    if (tc_r == 5'd0) begin
                        first_nz_s = idx_r;
                    end else begin
                        first_nz_s = first_nz_r;
                    end
                    if (t1_open_r && is_unit(c_s) && (t1_r != 2'd3)) begin
                        t1_s = t1_r + 2'd1;
                    end else begin
                        t1_open_s = 1'b0;
                    end
                end else begin
                    tc_s = tc_r;
                end
                // Modulo-16 arithmetic is exact here: the true count is 0..15.
                if (idx_r == start_r) begin
                    if (tc_s == 5'd0) begin
                        tz_s = 4'd0;
                    end else begin
                        tz_s = first_nz_s - start_r + 4'd1 - tc_s[3:0];
                    end
                    state_s = ST_STAT;
                end else begin
                    idx_s = idx_r - 4'd1;
                end
            end
            ST_STAT: begin
                stat_valid = 1'b1;
                if (stat_ready) begin
                    if (tc_r != 5'd0) begin
                        idx_s      = 4'd15;
                        emit_cnt_s = 5'd0;
                        state_s    = ST_EMIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STAT;
                end
            end
            ST_EMIT: begin
                if (nz_s) begin
                    coef_valid = 1'b1;
                    coef_last  = last_s;
                    if (coef_ready) begin
                        emit_cnt_s = emit_cnt_r + 5'd1;
                        if (last_s || (idx_r == start_r)) begin
                            state_s = ST_IDLE;
                        end else begin
                            idx_s = idx_r - 4'd1;
                        end
                    end else begin
                        state_s = ST_EMIT;
                    end
                end else if (idx_r == start_r) begin
                    state_s = ST_IDLE;
                end else begin
                    idx_s = idx_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Beat payload is forced to zero whenever no beat is offered
    always_comb begin
        if (coef_valid) begin
            coef_data = sel_s;
            coef_idx  = idx_r;
        end else begin
            coef_data = {COEF_W{1'b0}};
            coef_idx  = 4'd0;
        end
    end

    assign total_coeff = tc_r;
    assign trail_ones  = t1_r;
    assign total_zeros = tz_r;

endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// Self-checking bench for cavlc_scan_ctrl: directed cases plus random blocks
// checked against a list-based reference model of the block statistics.
module tb_cavlc_scan_ctrl;
    import cavlc_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    blk_valid;
    logic                    blk_ac;
    logic                    blk_ready;
    logic                    zz_wen;
    logic [NCOEF*COEF_W-1:0] zz_dout;
    logic                    stat_valid;
    logic                    stat_ready;
    logic [4:0]              total_coeff;
    logic [1:0]              trail_ones;
    logic [3:0]              total_zeros;
    logic                    coef_valid;
    logic                    coef_ready;
    logic [COEF_W-1:0]       coef_data;
    logic [3:0]              coef_idx;
    logic                    coef_last;

    int tests  = 0;
    int failed = 0;
    int blk[16];
    bit rnd_ready = 1'b0;

    cavlc_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .blk_valid   (blk_valid),
        .blk_ac      (blk_ac),
        .blk_ready   (blk_ready),
        .zz_wen      (zz_wen),
        .zz_dout     (zz_dout),
        .stat_valid  (stat_valid),
        .stat_ready  (stat_ready),
        .total_coeff (total_coeff),
        .trail_ones  (trail_ones),
        .total_zeros (total_zeros),
        .coef_valid  (coef_valid),
        .coef_ready  (coef_ready),
        .coef_data   (coef_data),
        .coef_idx    (coef_idx),
        .coef_last   (coef_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_block(input int v[16]);
        for (int k = 0; k < 16; k++) blk[k] = v[k];
    endtask

    task automatic check_idle_reset_outputs(input string tag);
        check({tag, "_blk_ready"}, 32'(blk_ready), 32'd1);
        check({tag, "_stat_valid"}, 32'(stat_valid), 32'd0);
        check({tag, "_coef_valid"}, 32'(coef_valid), 32'd0);
        check({tag, "_tc"}, 32'(total_coeff), 32'd0);
        check({tag, "_t1"}, 32'(trail_ones), 32'd0);
        check({tag, "_tz"}, 32'(total_zeros), 32'd0);
        check({tag, "_coef_data"}, 32'(coef_data), 32'd0);
        check({tag, "_coef_idx"}, 32'(coef_idx), 32'd0);
        check({tag, "_coef_last"}, 32'(coef_last), 32'd0);
    endtask

    // One complete block transaction; the DUT is expected idle on entry, at a negedge.
    task automatic run_block(input bit ac, input int stat_delay, input int stall_beat,
                             input int stall_len, input int rst_beat);
        int  start, e_tc, e_t1, e_tz, hi, lo, cyc, beat, guard, stall_left;
        bit  t1_open;
        int  bq_val[$];
        int  bq_idx[$];

        // reference model: list of non-zeros from the highest scan index down
        start = ac ? 1 : 0;
        e_tc = 0; e_t1 = 0; e_tz = 0; hi = -1; lo = 16; t1_open = 1'b1;
        for (int k = 15; k >= start; k--) begin
            if (blk[k] != 0) begin
                bq_val.push_back(blk[k]);
                bq_idx.push_back(k);
                if (hi < 0) hi = k;
                lo = k;
            end
        end
        e_tc = bq_val.size();
        foreach (bq_val[i]) begin
            if (t1_open && e_t1 < 3 && (bq_val[i] == 1 || bq_val[i] == -1)) e_t1++;
            else t1_open = 1'b0;
        end
        for (int k = start; k <= hi; k++) if (blk[k] == 0) e_tz++;

        for (int k = 0; k < 16; k++) zz_dout[k*COEF_W +: COEF_W] = COEF_W'(blk[k]);
        blk_ac    = ac;
        blk_valid = 1'b1;
        #1;
        check("accept_ready", 32'(blk_ready), 32'd1);
        check("accept_wen", 32'(zz_wen), 32'd1);
        @(negedge clk);
        blk_valid = 1'b0;
        #1;
        check("load_ready_low", 32'(blk_ready), 32'd0);

        cyc = 0;
        while (!stat_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("scan_cycles", 32'(cyc), 32'(17 - start));

        for (int d = 0; d <= stat_delay; d++) begin
            check("stat_valid", 32'(stat_valid), 32'd1);
            check("total_coeff", 32'(total_coeff), 32'(e_tc));
            check("trail_ones", 32'(trail_ones), 32'(e_t1));
            check("total_zeros", 32'(total_zeros), 32'(e_tz));
            check("stat_no_beat", 32'(coef_valid), 32'd0);
            if (d < stat_delay) @(negedge clk);
        end
        stat_ready = 1'b1;
        @(negedge clk);
        stat_ready = 1'b0;
        #1;
        check("stat_dropped", 32'(stat_valid), 32'd0);

        beat = 0; guard = 0; stall_left = stall_len;
        while (beat < e_tc && guard < 200) begin
            guard++;
            if (coef_valid) begin
                check("coef_data", 32'(coef_data), 32'(bq_val[beat] & 32'h7FFF));
                check("coef_idx", 32'(coef_idx), 32'(bq_idx[beat]));
                check("coef_last", 32'(coef_last), (beat == e_tc - 1) ? 32'd1 : 32'd0);
                check("stat_hold", 32'(total_coeff), 32'(e_tc));
                if (beat == rst_beat) begin
                    rst = 1'b1;
                    coef_ready = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    coef_ready = 1'b0;
                    #1;
                    check_idle_reset_outputs("mid_emit_rst");
                    return;
                end
                if (beat == stall_beat && stall_left > 0) begin
                    coef_ready = 1'b0;
                    stall_left--;
                end else if (rnd_ready && $urandom_range(0, 3) == 0) begin
                    coef_ready = 1'b0;
                end else begin
                    coef_ready = 1'b1;
                    beat++;
                end
            end else begin
                coef_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
        end
        coef_ready = 1'b0;
        #1;
        check("beats_done", 32'(beat), 32'(e_tc));
        if (e_tc != 0 && !rnd_ready && stall_len == 0) begin
            check("emit_cycles", 32'(guard), 32'(16 - lo));
        end
        check("back_idle", 32'(blk_ready), 32'd1);
        check("no_extra_beat", 32'(coef_valid), 32'd0);
        check("stat_readable", 32'(total_coeff), 32'(e_tc));
    endtask

    initial begin
        int b[16];

        rst = 1'b1; blk_valid = 1'b0; blk_ac = 1'b0; zz_dout = '0;
        stat_ready = 1'b0; coef_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_reset_outputs("reset");
        check("reset_wen", 32'(zz_wen), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1 full block
        b = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        set_block(b);
        run_block(1'b0, 0, -1, 0, -1);
        // T2 same block as AC
        run_block(1'b1, 0, -1, 0, -1);
        // T3 all zero
        b = '{default: 0};
        set_block(b);
        run_block(1'b0, 0, -1, 0, -1);
        // T4 more than three units
        b = '{1, -1, 1, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_block(b);
        run_block(1'b0, 0, -1, 0, -1);
        // T5 stalls on stats and on the second beat
        b = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        set_block(b);
        run_block(1'b0, 3, 1, 5, -1);
        // T6 reset in the middle of the emit pass, then a clean block
        run_block(1'b0, 0, -1, 0, 1);
        run_block(1'b0, 0, -1, 0, -1);
        // boundary: every index non-zero, including the most negative code
        for (int k = 0; k < 16; k++) b[k] = (k % 3 == 0) ? -16384 : k + 1;
        set_block(b);
        run_block(1'b0, 1, -1, 0, -1);

        rnd_ready = 1'b1;
        repeat (40) begin
            for (int k = 0; k < 16; k++) begin
                case ($urandom_range(0, 9))
                    5:       b[k] = 1;
                    6:       b[k] = -1;
                    7:       b[k] = int'($urandom_range(2, 16383)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                    8:       b[k] = -16384;
                    default: b[k] = 0;
                endcase
            end
            set_block(b);
            run_block(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 4), $urandom_range(0, 3), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
